cr_kme_fifo_arb: RTL and testbench
==================================

Name: cr_kme_fifo_arb

Overview:
Round-robin, burst-locking arbiter that shares one cr_kme 71-bit FIFO write port among N_REQ requesters. It sits directly in front of the FIFO's fifo_in / fifo_in_valid / fifo_in_stall interface. A registered output stage breaks the timing path from the requesters to the FIFO, and a stall only blocks the stage, never drops a beat. It also captures sticky FIFO error flags and burst-protocol violations for the KME status registers.

Parameters:
N_REQ, 4, number of requesters (2..8)
DW, 71, data width, matches FIFO entry width
MAX_BURST, 8, maximum beats per locked burst before a forced release (2..255)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  per-requester beat valid
req_data  in  N_REQ*DW  per-requester beat data; requester i occupies [i*DW +: DW]
req_last  in  N_REQ  beat is the last of a burst
req_ack  out  N_REQ  beat accepted this cycle (combinational)
fifo_in  out  DW  write data to FIFO
fifo_in_valid  out  1  write enable to FIFO
fifo_in_stall  in  1  FIFO has no free slot
fifo_overflow  in  1  FIFO overflow pulse
fifo_underflow  in  1  FIFO underflow pulse
err_clr  in  1  clears all sticky error flags
err_overflow  out  1  sticky, set by fifo_overflow
err_underflow  out  1  sticky, set by fifo_underflow
err_burst  out  1  sticky, set by a forced burst release
cur_owner  out  N_REQ  one-hot lock owner; 0 when IDLE
busy  out  1  state==LOCK or the output stage is full

Behaviour:
- Reset values: all outputs 0; stage empty; state IDLE; rr_ptr=N_REQ-1, so requester 0 has highest priority first; burst_cnt=0.

Output stage:
- One register (stage_full, stage_data).
- fifo_in=stage_data.
- fifo_in_valid = stage_full & ~fifo_in_stall, combinational.
- pop = fifo_in_valid.
- can_load = ~stage_full | pop.
- A beat acked in cycle t appears on fifo_in in cycle t+1. Minimum latency is 1 cycle; throughput is 1 beat/cycle while the FIFO is not stalled.
- Stall with the stage full: data is held, no ack is issued, nothing is lost.

FSM (IDLE, LOCK):
- IDLE:
  - If can_load and any req_valid, the winner w is the first valid index searching (rr_ptr+1) mod N_REQ upward with wrap.
  - req_ack[w]=1 and the beat is loaded the same cycle.
  - If req_last[w]: stay IDLE and set rr_ptr=w.
  - Otherwise: go to LOCK with owner=w and burst_cnt=1.
- LOCK:
  - Only the owner can be acked: req_ack[owner] = req_valid[owner] & can_load. All other requesters wait regardless of their valid.
  - On an ack with req_last: go to IDLE, rr_ptr=owner, burst_cnt=0.
  - On an ack without last where burst_cnt+1==MAX_BURST: set err_burst, go to IDLE, rr_ptr=owner. The beat is still delivered.
  - Otherwise: burst_cnt increments by 1.
  - An owner dropping req_valid mid-burst keeps the lock; there is no timeout.
- req_ack has at most one bit set, always. A requester must hold data and last stable until acked.
- burst_cnt is 8 bits and never exceeds MAX_BURST-1.

Errors:
- Error flags are set on an input pulse and cleared by err_clr.
- If set and err_clr occur in the same cycle, set wins.

Reset mid-operation:
- Asynchronous assertion immediately clears the stage, the FSM, and all flags.
- Any in-flight beat in the stage is discarded; the upstream requester must re-send.

Test Plan:
- After reset, pulse req_valid=4'b1111 with all req_last=1 for 4 cycles, no stall -> acks go to 0,1,2,3 in order; fifo_in_valid is high for cycles 1..4 with matching data.
- Requester 2 sends a 3-beat burst while requester 0 is continuously valid -> acks are 2,2,2 then 0; cur_owner=4'b0100 during the burst; no interleaving on fifo_in.
- Hold fifo_in_stall=1 for 5 cycles with the stage full -> fifo_in_valid=0, req_ack=0, fifo_in stable. On release, the held beat is written first, then the next beat, with no loss or duplication.
- With MAX_BURST=8, requester 1 sends 10 beats with no last -> err_burst=1 after beat 8 is acked; requester 3 (valid) is acked next; beat 8 is still written.
- Pulse fifo_overflow and fifo_underflow, then err_clr, then err_clr together with fifo_overflow -> flags go 1,1; then 0,0; then err_overflow=1.
- Assert rst during a LOCK with the stage full -> next cycle fifo_in_valid=0, cur_owner=0, busy=0, and all err flags=0.

Source files
------------

// File: rtl/cr_kme_fifo_arb.sv
`default_nettype none
// ============================================================================
//  Module   : cr_kme_fifo_arb
//  Purpose  : Round-robin, burst-locking arbiter sharing one cr_kme FIFO write
//             port among N_REQ requesters. A single registered output stage
//             decouples requester timing from the FIFO. A stall holds the
//             staged beat and never drops it. Sticky FIFO and burst-protocol
//             error flags are kept for the status registers.
//  Revision : 1.0 - initial release
// ============================================================================
module cr_kme_fifo_arb #(
  parameter int N_REQ     = 4,
  parameter int DW        = 71,
  parameter int MAX_BURST = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*DW-1:0]   req_data,
  input  logic [N_REQ-1:0]      req_last,
  output logic [N_REQ-1:0]      req_ack,
  output logic [DW-1:0]         fifo_in,
  output logic                  fifo_in_valid,
  input  logic                  fifo_in_stall,
  input  logic                  fifo_overflow,
  input  logic                  fifo_underflow,
  input  logic                  err_clr,
  output logic                  err_overflow,
  output logic                  err_underflow,
  output logic                  err_burst,
  output logic [N_REQ-1:0]      cur_owner,
  output logic                  busy
);

  localparam int         PW         = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_LOCK    = 1'b1;
  // Count value at which the next non-last beat forces the lock to release.
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]    burst_cnt_q, burst_cnt_d;
  logic          stage_full_q, stage_full_d;
  logic [DW-1:0] stage_data_q, stage_data_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_unf_q, err_unf_d;
  logic          err_bst_q, err_bst_d;

  logic          pop;
  logic          can_load;
  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] sel_idx;
  logic          take;
  logic [DW-1:0] sel_data;
  logic          sel_last;
  logic          burst_force;

  // Output stage drains whenever it holds a beat and the FIFO has room.
  assign pop      = stage_full_q & ~fifo_in_stall;
  assign can_load = ~stage_full_q | pop;

  // Round-robin search: first valid requester after rr_ptr, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      automatic logic [PW-1:0] idx = PW'((int'(rr_ptr_q) + k) % N_REQ);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // While locked only the owner may be served; otherwise the RR winner.
  always_comb begin
    take    = 1'b0;
    sel_idx = win_idx;
    if (state_q == ST_IDLE) begin
      take    = can_load & win_found;
      sel_idx = win_idx;
    end else begin
      take    = can_load & req_valid[owner_q];
      sel_idx = owner_q;
    end
  end

  // Data/last mux for the selected requester.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (PW'(i) == sel_idx) begin
        sel_data = req_data[i*DW +: DW];
      end
    end
    sel_last = req_last[sel_idx];
  end

  assign req_ack = take ? (N_REQ'(1) << sel_idx) : '0;

  // Arbitration FSM next-state: lock on a non-last beat, release on last
  // or when the burst reaches MAX_BURST beats (flagged as a protocol error).
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    burst_force = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          if (sel_last) begin
            rr_ptr_d = win_idx;
          end else begin
            state_d     = ST_LOCK;
            owner_d     = win_idx;
            burst_cnt_d = 8'd1;
          end
        end
      end
      ST_LOCK: begin
        if (take) begin
          if (sel_last) begin
            state_d     = ST_IDLE;
            rr_ptr_d    = owner_q;
            burst_cnt_d = 8'd0;
          end else if (burst_cnt_q == BURST_LAST) begin
            burst_force = 1'b1;
            state_d     = ST_IDLE;
            rr_ptr_d    = owner_q;
            burst_cnt_d = 8'd0;
          end else begin
            burst_cnt_d = burst_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stage loads on any ack (pop and load can coincide), else empties on pop.
  always_comb begin
    stage_full_d = stage_full_q;
    stage_data_d = stage_data_q;
    if (take) begin
      stage_full_d = 1'b1;
      stage_data_d = sel_data;
    end else if (pop) begin
      stage_full_d = 1'b0;
    end
  end

  // Sticky error flags; a set in the same cycle as err_clr wins.
  always_comb begin
    err_ovf_d = fifo_overflow  | (err_ovf_q & ~err_clr);
    err_unf_d = fifo_underflow | (err_unf_q & ~err_clr);
    err_bst_d = burst_force    | (err_bst_q & ~err_clr);
  end

  // State registers; reset discards any in-flight staged beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= PW'(N_REQ - 1);
      burst_cnt_q  <= 8'd0;
      stage_full_q <= 1'b0;
      stage_data_q <= '0;
      err_ovf_q    <= 1'b0;
      err_unf_q    <= 1'b0;
      err_bst_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      burst_cnt_q  <= burst_cnt_d;
      stage_full_q <= stage_full_d;
      stage_data_q <= stage_data_d;
      err_ovf_q    <= err_ovf_d;
      err_unf_q    <= err_unf_d;
      err_bst_q    <= err_bst_d;
    end
  end

  assign fifo_in       = stage_data_q;
  assign fifo_in_valid = pop;
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;
  assign err_burst     = err_bst_q;
  assign cur_owner     = (state_q == ST_LOCK) ? (N_REQ'(1) << owner_q) : '0;
  assign busy          = (state_q == ST_LOCK) | stage_full_q;

endmodule
`default_nettype wire

// File: tb/tb_cr_kme_fifo_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cr_kme_fifo_arb
//  Purpose  : Directed self-checking bench for cr_kme_fifo_arb (N_REQ=4,
//             DW=71, MAX_BURST=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cr_kme_fifo_arb;

  localparam int N  = 4;
  localparam int DW = 71;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ack;
  logic [DW-1:0]   fifo_in;
  logic            fifo_in_valid;
  logic            fifo_in_stall;
  logic            fifo_overflow;
  logic            fifo_underflow;
  logic            err_clr;
  logic            err_overflow;
  logic            err_underflow;
  logic            err_burst;
  logic [N-1:0]    cur_owner;
  logic            busy;

  int n_vec = 0;
  int n_err = 0;

  cr_kme_fifo_arb #(.N_REQ(N), .DW(DW), .MAX_BURST(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_last       (req_last),
    .req_ack        (req_ack),
    .fifo_in        (fifo_in),
    .fifo_in_valid  (fifo_in_valid),
    .fifo_in_stall  (fifo_in_stall),
    .fifo_overflow  (fifo_overflow),
    .fifo_underflow (fifo_underflow),
    .err_clr        (err_clr),
    .err_overflow   (err_overflow),
    .err_underflow  (err_underflow),
    .err_burst      (err_burst),
    .cur_owner      (cur_owner),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat payload tagged with requester and beat number.
  function automatic logic [DW-1:0] pat(int r, int n);
    return {7'h55, 32'(r), 32'(n)};
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(int r, logic [DW-1:0] d);
    req_data[r*DW +: DW] = d;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
    fifo_in_stall = 1'b0; fifo_overflow = 1'b0; fifo_underflow = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(posedge clk);

    // ---- reset state ----
    @(negedge clk); #1;
    chk("rst_valid", 128'(fifo_in_valid), 128'(0));
    chk("rst_fifo_in", 128'(fifo_in), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_owner", 128'(cur_owner), 128'(0));
    chk("rst_errs", 128'({err_overflow, err_underflow, err_burst}), 128'(0));
    rst = 1'b0;

    // ---- round-robin of single beats: 0,1,2,3 ----
    for (int i = 0; i < N; i++) set_data(i, pat(i, 0));
    for (int k = 0; k < N; k++) begin
      @(negedge clk); req_valid = 4'b1111; req_last = 4'b1111; #1;
      chk("rr_ack", 128'(req_ack), 128'(4'b0001 << k));
      @(posedge clk); #1;
      chk("rr_valid", 128'(fifo_in_valid), 128'(1));
      chk("rr_data", 128'(fifo_in), 128'(pat(k, 0)));
    end
    @(negedge clk); req_valid = '0; req_last = '0; #1;
    chk("rr_idle_ack", 128'(req_ack), 128'(0));
    @(posedge clk); #1;
    chk("rr_drain_valid", 128'(fifo_in_valid), 128'(0));
    chk("rr_drain_busy", 128'(busy), 128'(0));

    // ---- single beat from 1 moves rr_ptr to 1 ----
    @(negedge clk); req_valid = 4'b0010; req_last = 4'b0010; set_data(1, pat(1, 1)); #1;
    chk("pre_ack", 128'(req_ack), 128'(4'b0010));
    @(posedge clk); #1;
    chk("pre_data", 128'(fifo_in), 128'(pat(1, 1)));

    // ---- 3-beat burst from 2 while 0 is valid ----
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      req_valid = 4'b0101;
      req_last  = (b == 2) ? 4'b0101 : 4'b0001;
      set_data(2, pat(2, 10 + b)); set_data(0, pat(0, 5)); #1;
      chk("burst_ack", 128'(req_ack), 128'(4'b0100));
      @(posedge clk); #1;
      chk("burst_data", 128'(fifo_in), 128'(pat(2, 10 + b)));
      chk("burst_owner", 128'(cur_owner), 128'((b == 2) ? 4'b0000 : 4'b0100));
    end
    @(negedge clk); req_valid = 4'b0001; req_last = 4'b0001; #1;
    chk("after_burst_ack", 128'(req_ack), 128'(4'b0001));
    @(posedge clk); #1;
    chk("after_burst_data", 128'(fifo_in), 128'(pat(0, 5)));

    // ---- stall with the stage full for 5 cycles ----
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); fifo_in_stall = 1'b1; set_data(0, pat(0, 6)); #1;
      chk("stall_ack", 128'(req_ack), 128'(0));
      chk("stall_valid", 128'(fifo_in_valid), 128'(0));
      chk("stall_data", 128'(fifo_in), 128'(pat(0, 5)));
      chk("stall_busy", 128'(busy), 128'(1));
    end
    @(negedge clk); fifo_in_stall = 1'b0; #1;
    chk("unstall_valid", 128'(fifo_in_valid), 128'(1));
    chk("unstall_held", 128'(fifo_in), 128'(pat(0, 5)));
    chk("unstall_ack", 128'(req_ack), 128'(4'b0001));
    @(posedge clk); #1;
    chk("unstall_next", 128'(fifo_in), 128'(pat(0, 6)));
    chk("unstall_next_v", 128'(fifo_in_valid), 128'(1));
    @(negedge clk); req_valid = '0; req_last = '0;
    @(posedge clk); #1;
    chk("unstall_drain", 128'(fifo_in_valid), 128'(0));

    // ---- forced release after MAX_BURST beats from requester 1 ----
    set_data(3, pat(3, 7));
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk); req_valid = 4'b1010; req_last = 4'b1000;
      set_data(1, pat(1, 20 + n)); #1;
      chk("maxb_ack", 128'(req_ack), 128'(4'b0010));
      @(posedge clk); #1;
      chk("maxb_data", 128'(fifo_in), 128'(pat(1, 20 + n)));
      chk("maxb_err", 128'(err_burst), 128'((n == 8) ? 1 : 0));
      chk("maxb_owner", 128'(cur_owner), 128'((n == 8) ? 4'b0000 : 4'b0010));
    end
    @(negedge clk); set_data(1, pat(1, 29)); #1;
    chk("maxb_next_ack", 128'(req_ack), 128'(4'b1000));
    @(posedge clk); #1;
    chk("maxb_next_data", 128'(fifo_in), 128'(pat(3, 7)));
    chk("maxb_err_sticky", 128'(err_burst), 128'(1));
    @(negedge clk); req_valid = '0; req_last = '0;
    @(posedge clk); #1;
    chk("maxb_drain", 128'(fifo_in_valid), 128'(0));

    // ---- sticky error flags and clear priority ----
    @(negedge clk); fifo_overflow = 1'b1; fifo_underflow = 1'b1;
    @(posedge clk); #1;
    chk("err_set", 128'({err_overflow, err_underflow}), 128'(2'b11));
    @(negedge clk); fifo_overflow = 1'b0; fifo_underflow = 1'b0; err_clr = 1'b1;
    @(posedge clk); #1;
    chk("err_clr", 128'({err_overflow, err_underflow, err_burst}), 128'(3'b000));
    @(negedge clk); fifo_overflow = 1'b1;
    @(posedge clk); #1;
    chk("err_set_wins", 128'({err_overflow, err_underflow}), 128'(2'b10));
    @(negedge clk); fifo_overflow = 1'b0; err_clr = 1'b0;
    @(posedge clk); #1;
    chk("err_hold", 128'(err_overflow), 128'(1));

    // ---- asynchronous reset during LOCK with the stage full ----
    @(negedge clk); req_valid = 4'b0100; req_last = 4'b0000;
    set_data(2, pat(2, 40)); fifo_underflow = 1'b1; #1;
    chk("lock_ack", 128'(req_ack), 128'(4'b0100));
    @(posedge clk); #1;
    chk("lock_owner", 128'(cur_owner), 128'(4'b0100));
    chk("lock_busy", 128'(busy), 128'(1));
    chk("lock_unf", 128'(err_underflow), 128'(1));
    @(negedge clk); req_valid = '0; fifo_underflow = 1'b0; fifo_in_stall = 1'b1;
    @(posedge clk); #1;
    chk("lock_stalled", 128'(fifo_in_valid), 128'(0));
    #2; fifo_in_stall = 1'b0; rst = 1'b1; #1;
    chk("arst_valid", 128'(fifo_in_valid), 128'(0));
    chk("arst_owner", 128'(cur_owner), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_errs", 128'({err_overflow, err_underflow, err_burst}), 128'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_valid", 128'(fifo_in_valid), 128'(0));
    chk("post_rst_busy", 128'(busy), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
